// File: rtl/hdd_sd_sequencer_pkg.sv
// Shared types and defaults for the HDD-to-SD sequencer.
package hdd_sd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    // About one second of clk_sys at 14 MHz.
    localparam logic [23:0] DEFAULT_TIMEOUT_CYCLES = 24'd14_000_000;

endpackage

// File: rtl/hdd_sd_sequencer_if.sv
// Virtual-disk channel between the sequencer and hps_io.
interface hdd_sd_sequencer_if;

    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
    modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);

endinterface

// File: rtl/hdd_sd_sequencer_sd_ack_edge.sv
// Registered previous-ack compare producing single-cycle rise/fall pulses.
module sd_ack_edge (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ack,
    output logic rise,
    output logic fall
);

    logic ack_prev;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ack_prev <= 1'b0;
        end else begin
            ack_prev <= ack;
        end
    end

    assign rise = ack & ~ack_prev;
    assign fall = ~ack & ack_prev;

endmodule

// File: rtl/hdd_sd_sequencer.sv
// Queues core HDD read/write strobes and runs the hps_io sd_rd/sd_wr/sd_ack
// handshake, with mount/protect rejection and an ack timeout.
module hdd_sd_sequencer
    import hdd_sd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned SECTOR_W       = 16
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                hdd_read,
    input  logic                hdd_write,
    input  logic [SECTOR_W-1:0] hdd_sector,
    input  logic                img_mounted,
    input  logic [63:0]         img_size,
    input  logic                img_readonly,
    hdd_sd_sequencer_if.master  sd,
    output logic                cpu_wait,
    output logic                hdd_mounted,
    output logic                hdd_protect,
    output logic                err,
    output logic                busy
);

    state_t      state, state_nx;
    logic        rd_pend, rd_pend_nx;
    logic        wr_pend, wr_pend_nx;
    logic        sd_rd_q, sd_rd_nx;
    logic        sd_wr_q, sd_wr_nx;
    logic        cpu_wait_q, cpu_wait_nx;
    logic        err_q, err_nx;
    logic [31:0] lba_q, lba_nx;
    logic [23:0] cnt, cnt_nx;
    logic        ack_rise, ack_fall;
    logic        timed_out;

    sd_ack_edge u_ack_edge (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ack     (sd.sd_ack),
        .rise    (ack_rise),
        .fall    (ack_fall)
    );

    assign timed_out = (cnt == TIMEOUT_CYCLES - 24'd1);

    always_comb begin
        state_nx    = state;
        rd_pend_nx  = rd_pend | hdd_read;
        wr_pend_nx  = wr_pend | hdd_write;
        sd_rd_nx    = sd_rd_q;
        sd_wr_nx    = sd_wr_q;
        cpu_wait_nx = cpu_wait_q;
        err_nx      = err_q;
        lba_nx      = lba_q;
        cnt_nx      = cnt;

        case (state)
            IDLE: begin
                if (rd_pend || wr_pend) begin
                    // Clearing the selected flag still lets a same-cycle strobe re-arm it.
                    if (rd_pend) rd_pend_nx = hdd_read;
                    else         wr_pend_nx = hdd_write;

                    if (!hdd_mounted || (!rd_pend && hdd_protect)) begin
                        err_nx = 1'b1;
                    end else begin
                        lba_nx      = 32'(hdd_sector);
                        sd_rd_nx    = rd_pend;
                        sd_wr_nx    = !rd_pend;
                        cpu_wait_nx = 1'b1;
                        err_nx      = 1'b0;
                        cnt_nx      = 24'd0;
                        state_nx    = REQ;
                    end
                end
            end

            REQ, XFER: begin
                if (timed_out) begin
                    sd_rd_nx    = 1'b0;
                    sd_wr_nx    = 1'b0;
                    cpu_wait_nx = 1'b0;
                    err_nx      = 1'b1;
                    state_nx    = IDLE;
                end else begin
                    cnt_nx = cnt + 24'd1;
                    if (state == REQ && ack_rise) begin
                        sd_rd_nx = 1'b0;
                        sd_wr_nx = 1'b0;
                        state_nx = XFER;
                    end else if (state == XFER && ack_fall) begin
                        cpu_wait_nx = 1'b0;
                        state_nx    = IDLE;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rd_pend    <= 1'b0;
            wr_pend    <= 1'b0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            cpu_wait_q <= 1'b0;
            err_q      <= 1'b0;
            lba_q      <= 32'd0;
            cnt        <= 24'd0;
        end else if (clr) begin
            state      <= IDLE;
            rd_pend    <= 1'b0;
            wr_pend    <= 1'b0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            cpu_wait_q <= 1'b0;
            err_q      <= 1'b0;
            lba_q      <= 32'd0;
            cnt        <= 24'd0;
        end else begin
            state      <= state_nx;
            rd_pend    <= rd_pend_nx;
            wr_pend    <= wr_pend_nx;
            sd_rd_q    <= sd_rd_nx;
            sd_wr_q    <= sd_wr_nx;
            cpu_wait_q <= cpu_wait_nx;
            err_q      <= err_nx;
            lba_q      <= lba_nx;
            cnt        <= cnt_nx;
        end
    end

    // Mount state survives the warm clear; only the hard reset drops it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hdd_mounted <= 1'b0;
            hdd_protect <= 1'b0;
        end else if (img_mounted) begin
            hdd_mounted <= (img_size != 64'd0);
            hdd_protect <= img_readonly;
        end
    end

    assign sd.sd_lba = lba_q;
    assign sd.sd_rd  = sd_rd_q;
    assign sd.sd_wr  = sd_wr_q;
    assign cpu_wait  = cpu_wait_q;
    assign err       = err_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_hdd_sd_sequencer.sv
// Directed bench for hdd_sd_sequencer with a shortened ack timeout.
module tb_hdd_sd_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        clr = 1'b0;
    logic        hdd_read = 1'b0;
    logic        hdd_write = 1'b0;
    logic [15:0] hdd_sector = 16'd0;
    logic        img_mounted = 1'b0;
    logic [63:0] img_size = 64'd0;
    logic        img_readonly = 1'b0;
    logic        cpu_wait;
    logic        hdd_mounted;
    logic        hdd_protect;
    logic        err;
    logic        busy;

    int n_asserts = 0;
    int n_fail = 0;

    hdd_sd_sequencer_if sd_if ();

    hdd_sd_sequencer #(
        .TIMEOUT_CYCLES (24'd100),
        .SECTOR_W       (16)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .clr          (clr),
        .hdd_read     (hdd_read),
        .hdd_write    (hdd_write),
        .hdd_sector   (hdd_sector),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .img_readonly (img_readonly),
        .sd           (sd_if.master),
        .cpu_wait     (cpu_wait),
        .hdd_mounted  (hdd_mounted),
        .hdd_protect  (hdd_protect),
        .err          (err),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic mount(input logic [63:0] size, input logic ro);
        img_mounted  = 1'b1;
        img_size     = size;
        img_readonly = ro;
        step(1);
        img_mounted  = 1'b0;
    endtask

    always @(negedge clk_sys) begin
        if (reset_n) begin
            n_asserts++;
            assert ((sd_if.sd_rd & sd_if.sd_wr) === 1'b0)
            else begin
                n_fail++;
                $error("FAIL rd_wr_exclusive observed=1 expected=0");
            end
        end
    end

    initial begin
        sd_if.sd_ack = 1'b0;

        // Reset state
        step(1);
        chk("rst_sd_rd", sd_if.sd_rd, 0);
        chk("rst_sd_wr", sd_if.sd_wr, 0);
        chk("rst_cpu_wait", cpu_wait, 0);
        chk("rst_sd_lba", sd_if.sd_lba, 0);
        chk("rst_mounted", hdd_mounted, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        step(1);
        reset_n = 1'b1;
        step(1);

        // Unmounted read is rejected
        hdd_sector = 16'h0005;
        hdd_read = 1'b1;
        step(1);
        hdd_read = 1'b0;
        step(1);
        chk("unmnt_sd_rd", sd_if.sd_rd, 0);
        chk("unmnt_cpu_wait", cpu_wait, 0);
        chk("unmnt_err", err, 1);
        chk("unmnt_busy", busy, 0);
        step(1);
        chk("unmnt_sd_rd_later", sd_if.sd_rd, 0);
        mount(64'd0, 1'b0);
        chk("zero_size_mounted", hdd_mounted, 0);

        // Basic read
        mount(64'd512, 1'b0);
        chk("mnt_mounted", hdd_mounted, 1);
        chk("mnt_protect", hdd_protect, 0);
        hdd_sector = 16'h0123;
        hdd_read = 1'b1;
        step(1);
        hdd_read = 1'b0;
        chk("rd_not_yet", sd_if.sd_rd, 0);
        step(1);
        chk("rd_sd_rd", sd_if.sd_rd, 1);
        chk("rd_sd_lba", sd_if.sd_lba, 64'h0000_0123);
        chk("rd_cpu_wait", cpu_wait, 1);
        chk("rd_busy", busy, 1);
        chk("rd_err_cleared", err, 0);
        sd_if.sd_ack = 1'b1;
        step(1);
        chk("rd_sd_rd_drop", sd_if.sd_rd, 0);
        chk("rd_wait_held", cpu_wait, 1);
        step(4);
        chk("rd_wait_during_ack", cpu_wait, 1);
        sd_if.sd_ack = 1'b0;
        step(1);
        chk("rd_wait_drop", cpu_wait, 0);
        chk("rd_idle", busy, 0);
        chk("rd_err", err, 0);
        chk("rd_lba_hold", sd_if.sd_lba, 64'h0000_0123);

        // Write to a read-only image
        mount(64'd512, 1'b1);
        chk("ro_protect", hdd_protect, 1);
        hdd_sector = 16'h0044;
        hdd_write = 1'b1;
        step(1);
        hdd_write = 1'b0;
        step(1);
        chk("ro_sd_wr", sd_if.sd_wr, 0);
        chk("ro_cpu_wait", cpu_wait, 0);
        chk("ro_err", err, 1);
        step(1);
        chk("ro_sd_wr_later", sd_if.sd_wr, 0);
        hdd_sector = 16'h0042;
        hdd_read = 1'b1;
        step(1);
        hdd_read = 1'b0;
        step(1);
        chk("ro_read_sd_rd", sd_if.sd_rd, 1);
        chk("ro_read_err", err, 0);
        chk("ro_read_lba", sd_if.sd_lba, 64'h0000_0042);
        sd_if.sd_ack = 1'b1;
        step(2);
        sd_if.sd_ack = 1'b0;
        step(1);
        chk("ro_read_done", cpu_wait, 0);

        // Simultaneous read and write: read first, then write
        mount(64'd512, 1'b0);
        hdd_sector = 16'h0200;
        hdd_read = 1'b1;
        hdd_write = 1'b1;
        step(1);
        hdd_read = 1'b0;
        hdd_write = 1'b0;
        step(1);
        chk("both_sd_rd", sd_if.sd_rd, 1);
        chk("both_sd_wr", sd_if.sd_wr, 0);
        sd_if.sd_ack = 1'b1;
        step(1);
        chk("both_rd_drop", sd_if.sd_rd, 0);
        step(1);
        sd_if.sd_ack = 1'b0;
        step(1);
        chk("both_wait_drop", cpu_wait, 0);
        chk("both_wr_waiting", sd_if.sd_wr, 0);
        step(1);
        chk("both_sd_wr_up", sd_if.sd_wr, 1);
        chk("both_sd_rd_low", sd_if.sd_rd, 0);
        chk("both_wait_up", cpu_wait, 1);
        sd_if.sd_ack = 1'b1;
        step(1);
        chk("both_wr_drop", sd_if.sd_wr, 0);
        step(1);
        sd_if.sd_ack = 1'b0;
        step(1);
        chk("both_wr_done", cpu_wait, 0);

        // Timeout with no ack
        hdd_sector = 16'h0007;
        hdd_read = 1'b1;
        step(1);
        hdd_read = 1'b0;
        step(1);
        chk("to_sd_rd", sd_if.sd_rd, 1);
        step(99);
        chk("to_sd_rd_99", sd_if.sd_rd, 1);
        chk("to_wait_99", cpu_wait, 1);
        chk("to_busy_99", busy, 1);
        step(1);
        chk("to_sd_rd_100", sd_if.sd_rd, 0);
        chk("to_wait_100", cpu_wait, 0);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);

        // Asynchronous reset during XFER
        hdd_sector = 16'h0033;
        hdd_read = 1'b1;
        step(1);
        hdd_read = 1'b0;
        step(1);
        sd_if.sd_ack = 1'b1;
        step(1);
        chk("arst_in_xfer", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_sd_rd", sd_if.sd_rd, 0);
        chk("arst_sd_wr", sd_if.sd_wr, 0);
        chk("arst_cpu_wait", cpu_wait, 0);
        chk("arst_mounted", hdd_mounted, 0);
        chk("arst_busy", busy, 0);
        chk("arst_lba", sd_if.sd_lba, 0);
        sd_if.sd_ack = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(1);

        // Warm clear during XFER keeps the mount
        mount(64'd1024, 1'b0);
        hdd_sector = 16'h0099;
        hdd_read = 1'b1;
        step(1);
        hdd_read = 1'b0;
        step(1);
        sd_if.sd_ack = 1'b1;
        step(1);
        chk("clr_in_xfer_wait", cpu_wait, 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_sd_rd", sd_if.sd_rd, 0);
        chk("clr_cpu_wait", cpu_wait, 0);
        chk("clr_busy", busy, 0);
        chk("clr_mounted", hdd_mounted, 1);
        chk("clr_lba", sd_if.sd_lba, 0);
        chk("clr_err", err, 0);
        sd_if.sd_ack = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
